// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit feeding a small FIFO of {instr, pc} entries.
//
// Configuration macro: FETCH_QUEUE_BYPASS_EN
//   When defined, the current ROM word is presented straight on the head outputs whenever the
//   queue is empty in RUN. A bypassed word that is taken by a same-cycle deq is not stored.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             flush and begin fetching at start_address (wins over redirect)
//   start_address     initial fetch PC
//   redirect          taken-branch flush, resume fetching at redirect_pc
//   redirect_pc       branch target PC
//   rom_addr          ROM address, always the internal fetch PC
//   rom_data          combinational ROM word for rom_addr
//   deq               consumer accepts the head entry this cycle
//   instr_valid       head entry valid
//   instr_out         head instruction word (0 when not valid)
//   instr_pc          head instruction PC (0 when not valid)
//   count             number of occupied entries
module fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [6:0]               start_address,
  input  logic                     redirect,
  input  logic [6:0]               redirect_pc,
  output logic [6:0]               rom_addr,
  input  logic [8:0]               rom_data,
  input  logic                     deq,
  output logic                     instr_valid,
  output logic [8:0]               instr_out,
  output logic [6:0]               instr_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e          state_q;
  logic [6:0]      pc_q;
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   rptr_q;
  logic [CW-1:0]   count_q;
  logic [15:0]     mem_q [DEPTH];

  logic            flush;
  logic [6:0]      target;
  logic            stored_valid;
  logic            full;
  logic            pop;
  logic            fetch;
  logic            byp_active;
  logic            byp_taken;
  logic            enq;

  always_comb begin
    flush        = start | redirect;
    target       = start ? start_address : redirect_pc;
    stored_valid = (count_q != '0);
    full         = (count_q == CW'(DEPTH));
    pop          = stored_valid & deq & ~flush;
    // A full queue can still fetch when the head leaves in the same cycle.
    fetch        = (state_q == StRun) & (~full | deq) & ~flush;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp_active   = (state_q == StRun) & ~stored_valid;
    byp_taken    = byp_active & deq & ~flush;
`else
    byp_active   = 1'b0;
    byp_taken    = 1'b0;
`endif
    // A bypassed word consumed directly still advances the PC, but is never stored.
    enq          = fetch & ~byp_taken;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      state_q <= StRun;
      pc_q    <= target;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (fetch) begin
        // Last address: stop fetching rather than wrapping to 0.
        if (pc_q == 7'h7f) begin
          state_q <= StDrain;
        end else begin
          pc_q <= pc_q + 7'd1;
        end
      end
      if (enq) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      unique case ({enq, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wptr_q] <= {rom_data, pc_q};
    end
  end

  always_comb begin
    rom_addr = pc_q;
    count    = count_q;
    if (stored_valid) begin
      instr_valid = 1'b1;
      instr_out   = mem_q[rptr_q][15:7];
      instr_pc    = mem_q[rptr_q][6:0];
    end else if (byp_active) begin
      instr_valid = 1'b1;
      instr_out   = rom_data;
      instr_pc    = pc_q;
    end else begin
      instr_valid = 1'b0;
      instr_out   = '0;
      instr_pc    = '0;
    end
  end

endmodule
